// File: rtl/snd_pkg.sv
// Shared definitions for the PCM sample scheduler: FSM encoding, region
// count, terminator byte and small priority helpers.
package snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_READ = 3'd3,
    ST_CAPT = 3'd4
  } snd_state_e;

  localparam int unsigned SND_REGIONS = 4;
  localparam logic [7:0]  SND_TERM    = 8'hFF;

  // Lowest set index wins; callers only use the result when v is non-zero.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] id_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Mask of all IDs with strictly higher priority than id.
  function automatic logic [3:0] below_mask(input logic [1:0] id);
    return (4'b0001 << id) - 4'b0001;
  endfunction

endpackage

// File: rtl/pcm_scheduler_if.sv
// Bus between the PCM scheduler, its trigger sources, the PCM ROM and the mixer.
interface pcm_scheduler_if #(
  parameter int unsigned AW = 15
);
  import snd_pkg::*;

  logic [SND_REGIONS-1:0] KICK;
  logic [AW-1:0]          ROM_AD;
  logic                   ROM_RD;
  logic [7:0]             ROM_DT;
  logic [7:0]             SEPCM;
  logic                   BUSY;
  logic [1:0]             CUR_ID;
  logic                   DONE;

  modport master (
    output KICK,
    output ROM_DT,
    input  ROM_AD,
    input  ROM_RD,
    input  SEPCM,
    input  BUSY,
    input  CUR_ID,
    input  DONE
  );

  modport slave (
    input  KICK,
    input  ROM_DT,
    output ROM_AD,
    output ROM_RD,
    output SEPCM,
    output BUSY,
    output CUR_ID,
    output DONE
  );

endinterface

// File: rtl/snd_tick_div.sv
// Free-running sample-rate divider: counts 0..DIV-1 and flags the last count.
module snd_tick_div #(
  parameter int unsigned DIV = 3000
) (
  input  logic CLK24M,
  input  logic RESET_N,
  output logic TICK
);

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
  localparam logic [15:0] CNT_PRE  = 16'(DIV - 2);

  logic [15:0] cnt_r;
  logic        tick_r;

  // Counter and registered tick; tick is high exactly while cnt_r == DIV-1.
  always_ff @(posedge CLK24M or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r  <= 16'd0;
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
      tick_r <= (cnt_r == CNT_PRE);
    end
  end

  assign TICK = tick_r;

endmodule

// File: rtl/pcm_scheduler.sv
// Priority PCM sample scheduler: latches kick edges, plays one ROM region per
// sound ID at the tick rate, lets lower IDs preempt and flags natural ends.
module pcm_scheduler
  import snd_pkg::*;
#(
  parameter int unsigned DIV = 3000,
  parameter int unsigned AW  = 15
) (
  input  logic             CLK24M,
  input  logic             RESET_N,
  pcm_scheduler_if.slave   bus
);

  snd_state_e             state_r;
  snd_state_e             state_next_s;
  logic [SND_REGIONS-1:0] pend_r;
  logic [SND_REGIONS-1:0] pend_next_s;
  logic [SND_REGIONS-1:0] pend_clr_s;
  logic [SND_REGIONS-1:0] pend_eff_s;
  logic [SND_REGIONS-1:0] kick_prev_r;
  logic [SND_REGIONS-1:0] rise_s;
  logic [1:0]             sel_r;
  logic [1:0]             sel_next_s;
  logic [AW-1:0]          addr_r;
  logic [7:0]             sepcm_r;
  logic                   busy_r;
  logic [1:0]             cur_id_r;
  logic                   done_r;
  logic                   rom_rd_r;
  logic                   tick_s;
  logic                   last_byte_s;
  logic                   capt_end_s;
  logic                   capt_step_s;

  snd_tick_div #(.DIV(DIV)) u_tick_div (
    .CLK24M  (CLK24M),
    .RESET_N (RESET_N),
    .TICK    (tick_s)
  );

  assign rise_s      = bus.KICK & ~kick_prev_r;
  // A kick edge is visible to arbitration in the same cycle it is latched.
  assign pend_eff_s  = pend_r | rise_s;
  assign last_byte_s = &addr_r[AW-3:0];

  // Pending set/clear; a new edge beats the clear issued from LOAD.
  always_comb begin
    pend_clr_s = 4'b0000;
    if (state_r == ST_LOAD) begin
      pend_clr_s = id_onehot(sel_r);
    end else begin
      pend_clr_s = 4'b0000;
    end
    pend_next_s = (pend_r & ~pend_clr_s) | rise_s;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next_s = state_r;
    sel_next_s   = sel_r;
    capt_end_s   = 1'b0;
    capt_step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|pend_eff_s) begin
          state_next_s = ST_LOAD;
          sel_next_s   = lowest_set(pend_eff_s);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tick_s) begin
          state_next_s = ST_WAIT;
        end else if (|(pend_eff_s & below_mask(cur_id_r))) begin
          state_next_s = ST_LOAD;
          sel_next_s   = lowest_set(pend_eff_s & below_mask(cur_id_r));
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_READ: begin
        state_next_s = ST_CAPT;
      end
      ST_CAPT: begin
        if ((bus.ROM_DT == SND_TERM) || last_byte_s) begin
          state_next_s = ST_IDLE;
          capt_end_s   = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
          capt_step_s  = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, arbitration and kick history registers.
  always_ff @(posedge CLK24M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      sel_r       <= 2'd0;
      pend_r      <= 4'b0000;
      kick_prev_r <= 4'b0000;
    end else begin
      state_r     <= state_next_s;
      sel_r       <= sel_next_s;
      pend_r      <= pend_next_s;
      kick_prev_r <= bus.KICK;
    end
  end

  // Playback datapath and registered outputs.
  always_ff @(posedge CLK24M or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_r   <= '0;
      sepcm_r  <= 8'h00;
      busy_r   <= 1'b0;
      cur_id_r <= 2'd0;
      done_r   <= 1'b0;
      rom_rd_r <= 1'b0;
    end else begin
      rom_rd_r <= (state_next_s == ST_READ);
      done_r   <= capt_end_s;
      if (state_r == ST_LOAD) begin
        cur_id_r <= sel_r;
        addr_r   <= {sel_r, {(AW-2){1'b0}}};
        busy_r   <= 1'b1;
      end else if (capt_end_s) begin
        sepcm_r  <= 8'h00;
        busy_r   <= 1'b0;
      end else if (capt_step_s) begin
        sepcm_r  <= {1'b0, bus.ROM_DT[7:1]};
        addr_r   <= addr_r + AW'(1);
      end else begin
        addr_r   <= addr_r;
      end
    end
  end

  assign bus.ROM_AD = addr_r;
  assign bus.ROM_RD = rom_rd_r;
  assign bus.SEPCM  = sepcm_r;
  assign bus.BUSY   = busy_r;
  assign bus.CUR_ID = cur_id_r;
  assign bus.DONE   = done_r;

endmodule

// File: tb/tb_pcm_scheduler.sv
// Directed bench for pcm_scheduler with DIV=4, AW=15 and a behavioural ROM.
module tb_pcm_scheduler;

  localparam int DIV = 4;
  localparam int AW  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pcm_scheduler_if #(.AW(AW)) sif();

  pcm_scheduler #(.DIV(DIV), .AW(AW)) dut (
    .CLK24M  (clk),
    .RESET_N (rst_n),
    .bus     (sif)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (sif.ROM_RD) sif.ROM_DT <= rom[sif.ROM_AD];
  end

  // Sample log: SEPCM is recorded two cycles after each ROM read strobe.
  logic       rd_d1 = 1'b0;
  logic       rd_d2 = 1'b0;
  int         done_cnt = 0;
  logic [7:0] samples [$];

  always @(negedge clk) begin
    if (rd_d2) samples.push_back(sif.SEPCM);
    if (sif.DONE === 1'b1) done_cnt <= done_cnt + 1;
    rd_d2 <= rd_d1;
    rd_d1 <= sif.ROM_RD;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int d0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] smp(input int i);
    if (i < samples.size()) return samples[i];
    else return 8'hEE;
  endfunction

  task automatic pulse_kick(input int idx);
    @(negedge clk);
    sif.KICK[idx] = 1'b1;
    @(negedge clk);
    sif.KICK[idx] = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (sif.DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_busy_id(input logic [1:0] id, input int max_cyc, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (sif.BUSY === 1'b1 && sif.CUR_ID === id) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    sif.KICK = 4'b0000;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
    rom[15'h0000] = 8'd10; rom[15'h0001] = 8'd20; rom[15'h0002] = 8'd30; rom[15'h0003] = 8'hFF;
    rom[15'h2000] = 8'h02; rom[15'h2001] = 8'h04; rom[15'h2002] = 8'hFF;
    rom[15'h4000] = 8'h40; rom[15'h4001] = 8'h42; rom[15'h4002] = 8'h44;
    rom[15'h4003] = 8'h46; rom[15'h4004] = 8'h48; rom[15'h4005] = 8'hFF;
    for (int i = 15'h6000; i < (1 << AW); i++) rom[i] = 8'h22;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sepcm", 32'(sif.SEPCM), 32'h00);
    check("rst_busy", 32'(sif.BUSY), 32'd0);
    check("rst_done", 32'(sif.DONE), 32'd0);
    check("rst_rd", 32'(sif.ROM_RD), 32'd0);
    check("rst_ad", 32'(sif.ROM_AD), 32'h0000);
    check("rst_id", 32'(sif.CUR_ID), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ID 0 plays 10,20,30 then hits the terminator
    samples.delete();
    d0 = done_cnt;
    pulse_kick(0);
    wait_done(100, "t1_done_seen");
    repeat (2) @(negedge clk);
    check("t1_nsamp", 32'(samples.size()), 32'd4);
    check("t1_s0", 32'(smp(0)), 32'h05);
    check("t1_s1", 32'(smp(1)), 32'h0A);
    check("t1_s2", 32'(smp(2)), 32'h0F);
    check("t1_s3", 32'(smp(3)), 32'h00);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_busy", 32'(sif.BUSY), 32'd0);
    check("t1_id", 32'(sif.CUR_ID), 32'd0);

    // ID 1 preempts ID 2 at the next tick without DONE
    pulse_kick(2);
    wait_busy_id(2'd2, 20, "t2_start2");
    d0 = done_cnt;
    pulse_kick(1);
    wait_busy_id(2'd1, 20, "t2_preempt");
    samples.delete();
    check("t2_ad", 32'(sif.ROM_AD), 32'h2000);
    check("t2_no_done", 32'(done_cnt - d0), 32'd0);
    wait_done(100, "t2_done_seen");
    repeat (2) @(negedge clk);
    check("t2_nsamp", 32'(samples.size()), 32'd3);
    check("t2_s0", 32'(smp(0)), 32'h01);
    check("t2_s1", 32'(smp(1)), 32'h02);
    check("t2_s2", 32'(smp(2)), 32'h00);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_id_hold", 32'(sif.CUR_ID), 32'd1);
    check("t2_busy", 32'(sif.BUSY), 32'd0);

    // ID 3 waits for ID 1, then runs to the last byte of its region
    pulse_kick(1);
    wait_busy_id(2'd1, 20, "t3_start1");
    pulse_kick(3);
    wait_done(100, "t3_done1_seen");
    check("t3_done1_id", 32'(sif.CUR_ID), 32'd1);
    wait_busy_id(2'd3, 10, "t3_start3");
    samples.delete();
    check("t3_ad3", 32'(sif.ROM_AD), 32'h6000);
    wait_done(40000, "t3_done3_seen");
    check("t3_end_ad", 32'(sif.ROM_AD), 32'h7FFF);
    check("t3_end_id", 32'(sif.CUR_ID), 32'd3);
    repeat (2) @(negedge clk);
    check("t3_nsamp", 32'(samples.size()), 32'd8192);
    check("t3_first", 32'(smp(0)), 32'h11);
    check("t3_penult", 32'(smp(8190)), 32'h11);
    check("t3_last", 32'(smp(8191)), 32'h00);

    // Held kick level triggers exactly one playback
    d0 = done_cnt;
    @(negedge clk);
    sif.KICK[2] = 1'b1;
    repeat (100) @(negedge clk);
    sif.KICK[2] = 1'b0;
    repeat (50) @(negedge clk);
    check("t4_one_play", 32'(done_cnt - d0), 32'd1);
    check("t4_busy", 32'(sif.BUSY), 32'd0);

    // Asynchronous reset mid-playback
    pulse_kick(2);
    wait_busy_id(2'd2, 20, "t5_start2");
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_sepcm", 32'(sif.SEPCM), 32'h00);
    check("t5_busy", 32'(sif.BUSY), 32'd0);
    check("t5_done", 32'(sif.DONE), 32'd0);
    check("t5_rd", 32'(sif.ROM_RD), 32'd0);
    check("t5_ad", 32'(sif.ROM_AD), 32'h0000);
    check("t5_id", 32'(sif.CUR_ID), 32'd0);
    @(negedge clk);
    sif.KICK[0] = 1'b1;
    @(negedge clk);
    sif.KICK[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle_busy", 32'(sif.BUSY), 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // Kick coincident with DONE replays ID 0 from its base
    pulse_kick(0);
    wait_done(100, "t6_done1_seen");
    sif.KICK[0] = 1'b1;
    @(negedge clk);
    sif.KICK[0] = 1'b0;
    wait_busy_id(2'd0, 10, "t6_replay");
    samples.delete();
    check("t6_ad", 32'(sif.ROM_AD), 32'h0000);
    wait_done(100, "t6_done2_seen");
    repeat (2) @(negedge clk);
    check("t6_nsamp", 32'(samples.size()), 32'd4);
    check("t6_s0", 32'(smp(0)), 32'h05);
    check("t6_s2", 32'(smp(2)), 32'h0F);
    check("t6_s3", 32'(smp(3)), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
